axis_frame_tx: RTL and testbench
================================

AXIS_FRAME_TX -- requirements
Module: axis_frame_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries in front of the output register (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100, consecutive stall cycles before the watchdog fires.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  push request for a write-side word.
REQ-006 SHALL have port wr_data  input  64  write-side payload.
REQ-007 SHALL have port wr_last  input  1  marks the pushed word as end of frame.
REQ-008 SHALL have port wr_full  output  1  FIFO holds DEPTH entries; pushes are ignored.
REQ-009 SHALL have port TDATA  output  64  stream payload.
REQ-010 SHALL have port TVALID  output  1  stream word valid.
REQ-011 SHALL have port TLAST  output  1  stream end of frame.
REQ-012 SHALL have port TREADY  input  1  downstream ready.
REQ-013 SHALL have port frame_cnt  output  16  count of frames completed on the stream.
REQ-014 SHALL have port timeout_err  output  1  sticky backpressure watchdog flag.

Function
REQ-015 SHALL accept a push when wr_en=1 and wr_full=0, storing {wr_data, wr_last}; a push with wr_full=1 SHALL be dropped with no state change.
REQ-016 SHALL use an output register (TDATA/TLAST/TVALID) loaded from the FIFO head when TVALID=0 or a handshake (TVALID&&TREADY) occurs.
REQ-017 SHALL bypass the FIFO: a push into an empty FIFO with an empty output register appears with TVALID=1 on the next cycle (latency 1).
REQ-018 SHALL hold TDATA, TLAST and TVALID stable while TVALID=1 and TREADY=0.
REQ-019 SHALL never drive TLAST=1 while TVALID=0.
REQ-020 SHALL sustain one word per cycle while TREADY=1 and the FIFO is non-empty.
REQ-021 SHALL compute wr_full from the registered occupancy; a pop in the same cycle SHALL NOT make a full FIFO accept a push.
REQ-022 SHALL accept simultaneous push and pop on a non-full FIFO, leaving the occupancy unchanged.
REQ-023 SHALL implement FSM IDLE (TVALID=0), SEND (TVALID=1, TREADY=1), STALL (TVALID=1, TREADY=0).
REQ-024 SHALL transition IDLE->SEND/STALL when the output register loads, SEND->STALL when TREADY drops, STALL->SEND/IDLE on handshake depending on FIFO occupancy.
REQ-025 SHALL increment frame_cnt by 1 on each handshake with TLAST=1, wrapping 16'hFFFF->16'h0000.

Reset
REQ-026 SHALL on rst=0 asynchronously clear TVALID, TLAST, TDATA (64'h0), wr_full, frame_cnt, timeout_err, FIFO pointers and occupancy, and set FSM to IDLE.
REQ-027 SHALL discard a partially sent frame on reset mid-frame; after release, the first stream word is the first word pushed after release.

Configuration
REQ-028 SHALL, when AXIS_TX_WATCHDOG_EN is defined, count consecutive STALL cycles, clear the count on any non-STALL cycle, and set timeout_err when the count reaches TIMEOUT_CYCLES.
REQ-029 SHALL keep timeout_err sticky until reset, and SHALL NOT affect the data path when it is set.
REQ-030 SHALL, when AXIS_TX_WATCHDOG_EN is undefined, tie timeout_err to 0 and omit the counter logic.

Verification
REQ-031 SHALL cover single-word frame: push 64'hA5 with wr_last=1 into an idle block, TREADY=1 -> next cycle TVALID=1, TDATA=64'hA5, TLAST=1, then frame_cnt=1.
REQ-032 SHALL cover backpressure: push 3 words, TREADY=0 for 10 cycles -> TDATA and TLAST stable and TVALID=1 throughout; release -> 3 handshakes in consecutive cycles.
REQ-033 SHALL cover full: TREADY=0, push DEPTH+2 words -> wr_full=1 after output register + DEPTH words; extra words are absent from the stream.
REQ-034 SHALL cover wrap: preset 65535 completed frames (or force) then send one frame -> frame_cnt=0.
REQ-035 SHALL cover the watchdog (macro defined): TVALID=1, TREADY=0 for TIMEOUT_CYCLES -> timeout_err=1 and held after TREADY=1; macro undefined -> timeout_err=0 always.
REQ-036 SHALL cover reset mid-frame: assert rst=0 after 2 of 4 words -> TVALID=0 immediately; after release, the next frame is sent intact and frame_cnt starts at 0.

Source files
------------

// File: rtl/axis_frame_tx_if.sv
// Write-side push port and AXI-Stream master bundle for axis_frame_tx.
// master = producer/consumer environment, slave = the frame transmitter.
interface axis_frame_tx_if;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        wr_last;
  logic        wr_full;
  logic [63:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (
    output wr_en, wr_data, wr_last, TREADY,
    input  wr_full, TDATA, TVALID, TLAST
  );

  modport slave (
    input  wr_en, wr_data, wr_last, TREADY,
    output wr_full, TDATA, TVALID, TLAST
  );
endinterface

// File: rtl/axis_frame_tx.sv
// FIFO-fed AXI-Stream frame transmitter with registered output and frame counter.
// Optional stall watchdog enabled by defining AXIS_TX_WATCHDOG_EN.
module axis_frame_tx #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  axis_frame_tx_if.slave    bus,
  output logic [15:0]       frame_cnt,
  output logic              timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    STALL
  } state_t;

  state_t         state_q, state_d;
  logic [64:0]    mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    tdata_q, tdata_d;
  logic           tlast_q, tlast_d;
  logic [15:0]    frame_q;

  logic           tvalid;
  logic           hs;
  logic           load;
  logic           full;
  logic           empty;
  logic           push;
  logic           bypass;
  logic           pop;
  logic           fifo_wr;
  logic [64:0]    head;

  assign tvalid  = (state_q != IDLE);
  assign hs      = tvalid && bus.TREADY;
  assign load    = !tvalid || hs;
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push    = bus.wr_en && !full;
  // Empty FIFO and free output slot: word skips the FIFO.
  assign bypass  = load && empty && push;
  assign pop     = load && !empty;
  assign fifo_wr = push && !bypass;
  assign head    = mem_q[rptr_q];
  assign cnt_d   = cnt_q + CW'(fifo_wr) - CW'(pop);

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    if (load) begin
      unique case (1'b1)
        pop: begin
          tdata_d = head[64:1];
          tlast_d = head[0];
        end
        bypass: begin
          tdata_d = bus.wr_data;
          tlast_d = bus.wr_last;
        end
        default: tlast_d = 1'b0;
      endcase
    end
    unique case (state_q)
      IDLE: begin
        if (pop || bypass)
          state_d = bus.TREADY ? SEND : STALL;
      end
      SEND: begin
        if (!bus.TREADY)
          state_d = STALL;
        else if (!(pop || bypass))
          state_d = IDLE;
      end
      STALL: begin
        if (bus.TREADY)
          state_d = (pop || bypass) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr)
      mem_q[wptr_q] <= {bus.wr_data, bus.wr_last};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      cnt_q   <= cnt_d;
      if (fifo_wr)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      if (hs && tlast_q)
        frame_q <= frame_q + 16'd1;
    end
  end

`ifdef AXIS_TX_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q;
  logic          err_q;
  logic          stall;

  assign stall = tvalid && !bus.TREADY;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!stall)
        wd_q <= '0;
      else if (wd_q != WW'(TIMEOUT_CYCLES))
        wd_q <= wd_q + WW'(1);
      if (stall && wd_q == WW'(TIMEOUT_CYCLES - 1))
        err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign bus.wr_full = full;
  assign bus.TDATA   = tdata_q;
  assign bus.TLAST   = tlast_q;
  assign bus.TVALID  = tvalid;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed and randomized bench for axis_frame_tx against a queue-based
// model of the stream (output register plus FIFO as one ordered queue).
module tb_axis_frame_tx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  axis_frame_tx_if bus ();

  axis_frame_tx #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  word_t       q[$];
  logic [15:0] frames_m;
  bit          err_m;
  int          stall_run;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", 64'(bus.TVALID), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("tdata", bus.TDATA, q[0].d);
      chk("tlast", 64'(bus.TLAST), 64'(q[0].l));
    end else begin
      chk("tlast_idle", 64'(bus.TLAST), 64'(0));
    end
    chk("wr_full", 64'(bus.wr_full), 64'(q.size() == DEPTH + 1));
    chk("frame_cnt", 64'(frame_cnt), 64'(frames_m));
    chk("timeout_err", 64'(timeout_err), 64'(err_m));
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input bit we, input logic [63:0] d, input bit l,
                       input bit rdy);
    bit full_m, hs, stall;
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.wr_last = l;
    bus.TREADY  = rdy;
    #1;
    check_outputs();
    full_m = (q.size() == DEPTH + 1);
    hs     = (q.size() > 0) && rdy;
    stall  = (q.size() > 0) && !rdy;
    @(posedge clk);
    if (hs) begin
      if (q[0].l) frames_m++;
      void'(q.pop_front());
    end
    if (we && !full_m) q.push_back('{d: d, l: l});
    stall_run = stall ? stall_run + 1 : 0;
`ifdef AXIS_TX_WATCHDOG_EN
    if (stall_run >= TIMEOUT) err_m = 1'b1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.TREADY = 1'b0;
    rst        = 1'b0;
    #1;
    chk("rst_tvalid", 64'(bus.TVALID), 64'(0));
    chk("rst_tlast", 64'(bus.TLAST), 64'(0));
    chk("rst_tdata", bus.TDATA, 64'h0);
    chk("rst_full", 64'(bus.wr_full), 64'(0));
    chk("rst_frame", 64'(frame_cnt), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));
    q.delete();
    frames_m  = '0;
    err_m     = 1'b0;
    stall_run = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    bus.TREADY  = 1'b0;
    vectors     = 0;
    miscompares = 0;
    frames_m    = '0;
    err_m       = 1'b0;
    stall_run   = 0;

    do_reset();

    // single-word frame
    cycle(1'b1, 64'hA5, 1'b1, 1'b1);
    chk("single_valid", 64'(bus.TVALID), 64'(1));
    chk("single_data", bus.TDATA, 64'hA5);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("single_cnt", 64'(frame_cnt), 64'(1));

    // backpressure
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'hB0 + 64'(i), i == 2, 1'b0);
    repeat (10) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("bp_cnt", 64'(frame_cnt), 64'(2));

    // full: output register + DEPTH words, extra pushes dropped
    for (int i = 0; i < DEPTH + 2; i++)
      cycle(1'b1, 64'hC0 + 64'(i), i == DEPTH, 1'b0);
    chk("full_set", 64'(bus.wr_full), 64'(1));
    repeat (DEPTH + 3) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("full_drained", 64'(bus.TVALID), 64'(0));
    chk("full_cnt", 64'(frame_cnt), 64'(3));

    // watchdog
    cycle(1'b1, 64'hD0, 1'b1, 1'b0);
    repeat (TIMEOUT) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
`ifdef AXIS_TX_WATCHDOG_EN
    chk("wd_sticky", 64'(timeout_err), 64'(1));
`else
    chk("wd_off", 64'(timeout_err), 64'(0));
`endif

    // reset mid-frame
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'hE0 + 64'(i), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 64'hF0 + 64'(i), i == 3, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("mid_rst_cnt", 64'(frame_cnt), 64'(1));

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 6, {$urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    repeat (DEPTH + 3) cycle(1'b0, '0, 1'b0, 1'b1);

    // frame counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++)
      cycle(1'b1, 64'(i), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("wrap_max", 64'(frame_cnt), 64'hFFFF);
    cycle(1'b1, 64'h1234, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("wrap_zero", 64'(frame_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
